mac_unit: RTL and testbench
===========================

// Module: mac_unit
// PURPOSE
//   Registered multiply-accumulate element for the TinyML datapath: acc_out <= acc_in + a*b each clock.
//   Accumulation is external: the caller feeds acc_out (or a neighbour's result) back on acc_in.
//   One output register, no handshake; a new operation may be issued every cycle.
// PARAMETERS
//   DATA_W  8   width of operands a and b
//   ACC_W   16  width of acc_in/acc_out; must be >= 2*DATA_W
//   SIGNED  0   0: a, b, acc_in and acc_out are unsigned; 1: all are two's complement
// PORTS
//   clk     in   1       rising-edge clock; the only clock
//   reset   in   1       asynchronous, active-low reset (asserted when 0)
//   a       in   DATA_W  multiplicand
//   b       in   DATA_W  multiplier
//   acc_in  in   ACC_W   accumulator input (addend)
//   acc_out out  ACC_W   registered result
// BEHAVIOUR
//   - Reset: while reset==0, acc_out is 0 immediately, without waiting for clk. It stays 0 until the
//     first rising clk edge after reset returns to 1.
//   - Operation: every rising clk edge with reset==1 does acc_out <= acc_in + a*b.
//   - Latency: 1 cycle. There is no stall or enable; every edge updates acc_out.
//   - Product width: product = a*b, computed at full 2*DATA_W width. It is zero-extended (SIGNED=0)
//     or sign-extended (SIGNED=1) to ACC_W bits.
//   - Sum width: sum = acc_in + product, computed internally at ACC_W+1 bits.
//   - Overflow, default (macro absent): the sum wraps modulo 2^ACC_W, i.e. low ACC_W bits kept.
//   - Zero operand: a==0 or b==0 gives acc_out = acc_in after the edge (pass-through).
//   - Inputs may change anywhere outside the setup/hold window. No combinational path from the
//     inputs to acc_out.
//   - Reset mid-stream: in-flight result discarded; the first result after release uses the
//     inputs present at that edge.
// CONFIGURATION
//   - MAC_UNIT_SAT_EN defined: on overflow, acc_out clamps instead of wrapping.
//       SIGNED=0: clamps to 2^ACC_W-1.
//       SIGNED=1: clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), by the sign of the true sum.
//   - MAC_UNIT_SAT_EN undefined: wrap-around as above. No saturation logic is synthesised.
//   - Port list is identical in both builds.
// STRUCTURE
//   - Shared package mac_pkg:
//       default widths MAC_DATA_W=8, MAC_ACC_W=16
//       saturation bound constants / functions (max/min for signed and unsigned)
//   - One sub-module, mac_mult: combinational DATA_W x DATA_W -> 2*DATA_W multiplier,
//     signed/unsigned selected by SIGNED.
//   - mac_unit contains: mac_mult instance, extension, adder, optional saturation, output register.
// TESTING (clk period 10 ns; inputs driven away from the rising edge)
//   1. Reset: hold reset=0 with a=3, b=4, acc_in=5 -> acc_out=0, including with no clock edge.
//   2. Single MAC: reset=1, a=3, b=4, acc_in=0 -> acc_out=12 after the next rising edge.
//   3. Chained: after step 2, a=2, b=5, acc_in=acc_out (12) -> acc_out=22 after the next edge.
//   4. Overflow, SIGNED=0: a=255, b=255, acc_in=16'hFFFF -> acc_out=16'hFE00 (wrap build);
//      acc_out=16'hFFFF with MAC_UNIT_SAT_EN.
//   5. SIGNED=1: a=8'hFF (-1), b=2, acc_in=16'h0005 -> acc_out=16'h0003.
//      a=8'h80, b=8'h80, acc_in=16'h7FFF -> 16'hBFFF (wrap build) / 16'h7FFF (sat build).
//   6. Async reset mid-stream: drop reset to 0 between edges -> acc_out=0 before the next edge.
//      Release with a=1, b=1, acc_in=7 -> acc_out=8 one edge later.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and overflow classification for the TinyML MAC element
// Contents:
//   MAC_DATA_W, MAC_ACC_W : default operand and accumulator widths
//   sat_sel_e             : which saturation bound (if any) a sum must clamp to
//   sat_check()           : classifies an ACC_W+1 bit sum as in range, above max or below min
package mac_pkg;

   localparam int MAC_DATA_W = 8;
   localparam int MAC_ACC_W  = 16;

   typedef enum logic [1:0] {
      SAT_NONE = 2'd0,
      SAT_HI   = 2'd1,
      SAT_LO   = 2'd2
   } sat_sel_e;

   // carry is bit ACC_W of the widened sum, top is bit ACC_W-1.
   // Unsigned: a carry out means the true sum exceeded 2^ACC_W-1.
   // Signed: bits ACC_W and ACC_W-1 disagree only when the result left the
   // ACC_W-bit range; bit ACC_W is then the sign of the true sum.
   function automatic sat_sel_e sat_check(input logic is_signed,
                                          input logic carry,
                                          input logic top);
      sat_sel_e sel;
      sel = SAT_NONE;
      if (!is_signed) begin
         if (carry) sel = SAT_HI;
      end else if (carry != top) begin
         sel = carry ? SAT_LO : SAT_HI;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mac_mult.sv
// rtl/mac_mult.sv - combinational DATA_W x DATA_W -> 2*DATA_W multiplier
// Ports:
//   a       in   DATA_W    multiplicand
//   b       in   DATA_W    multiplier
//   product out  2*DATA_W  full-width product, two's complement when SIGNED=1
module mac_mult #(
   parameter int DATA_W = 8,
   parameter int SIGNED = 0
) (
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic [2*DATA_W-1:0] product
);

   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] b_ext;
   logic                a_fill;
   logic                b_fill;

   // Extending both operands to the product width first makes the low
   // 2*DATA_W bits of a plain multiply exact for both number systems.
   assign a_fill = (SIGNED != 0) & a[DATA_W-1];
   assign b_fill = (SIGNED != 0) & b[DATA_W-1];
   assign a_ext  = {{DATA_W{a_fill}}, a};
   assign b_ext  = {{DATA_W{b_fill}}, b};

   assign product = a_ext * b_ext;

endmodule

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - registered multiply-accumulate: acc_out <= acc_in + a*b every clock
// Build option: MAC_UNIT_SAT_EN clamps overflowing sums instead of wrapping.
// Ports:
//   clk     in   1       rising-edge clock
//   reset   in   1       asynchronous reset, active low
//   a       in   DATA_W  multiplicand
//   b       in   DATA_W  multiplier
//   acc_in  in   ACC_W   addend, normally acc_out or a neighbour's result
//   acc_out out  ACC_W   registered result, one cycle latency
module mac_unit
   import mac_pkg::*;
#(
   parameter int DATA_W = MAC_DATA_W,
   parameter int ACC_W  = MAC_ACC_W,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  acc_out
);

   // Bits needed to widen the product to the ACC_W+1 bit sum.
   localparam int EXT = ACC_W + 1 - 2 * DATA_W;

   logic [2*DATA_W-1:0] product;
   logic                prod_fill;
   logic                acc_fill;
   logic [ACC_W:0]      prod_x;
   logic [ACC_W:0]      acc_x;
   logic [ACC_W:0]      sum;
   logic [ACC_W-1:0]    next_acc;

   mac_mult #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED)
   ) u_mult (
      .a       (a),
      .b       (b),
      .product (product)
   );

   assign prod_fill = (SIGNED != 0) & product[2*DATA_W-1];
   assign acc_fill  = (SIGNED != 0) & acc_in[ACC_W-1];
   assign prod_x    = {{EXT{prod_fill}}, product};
   assign acc_x     = {acc_fill, acc_in};
   assign sum       = acc_x + prod_x;

`ifdef MAC_UNIT_SAT_EN
   localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};
   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   sat_sel_e sat_sel;

   assign sat_sel = sat_check(SIGNED != 0, sum[ACC_W], sum[ACC_W-1]);

   always_comb begin
      next_acc = sum[ACC_W-1:0];
      case (sat_sel)
         SAT_HI:  next_acc = (SIGNED != 0) ? S_MAX : U_MAX;
         SAT_LO:  next_acc = S_MIN;
         default: next_acc = sum[ACC_W-1:0];
      endcase
   end
`else
   // Wrap-around: only the low ACC_W bits survive.
   logic unused_sum_msb;
   assign unused_sum_msb = sum[ACC_W];
   assign next_acc       = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_out <= '0;
      end else begin
         acc_out <= next_acc;
      end
   end

endmodule

// File: tb/tb_mac_unit.sv
// tb/tb_mac_unit.sv - directed self-checking bench for mac_unit, unsigned and signed instances
module tb_mac_unit;

`ifdef MAC_UNIT_SAT_EN
   localparam logic [15:0] EXP_U_OVF     = 16'hFFFF;
   localparam logic [15:0] EXP_S_OVF_POS = 16'h7FFF;
   localparam logic [15:0] EXP_S_OVF_NEG = 16'h8000;
`else
   localparam logic [15:0] EXP_U_OVF     = 16'hFE00;
   localparam logic [15:0] EXP_S_OVF_POS = 16'hBFFF;
   localparam logic [15:0] EXP_S_OVF_NEG = 16'h4080;
`endif

   logic        clk;
   logic        reset;
   logic [7:0]  u_a, u_b, s_a, s_b;
   logic [15:0] u_acc_in, s_acc_in;
   logic [15:0] u_acc_out, s_acc_out;

   int tests;
   int failures;

   mac_unit #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) u_dut_u (
      .clk     (clk),
      .reset   (reset),
      .a       (u_a),
      .b       (u_b),
      .acc_in  (u_acc_in),
      .acc_out (u_acc_out)
   );

   mac_unit #(.DATA_W(8), .ACC_W(16), .SIGNED(1)) u_dut_s (
      .clk     (clk),
      .reset   (reset),
      .a       (s_a),
      .b       (s_b),
      .acc_in  (s_acc_in),
      .acc_out (s_acc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_u(input logic [7:0] a, input logic [7:0] b, input logic [15:0] acc);
      u_a = a; u_b = b; u_acc_in = acc;
   endtask

   task automatic drive_s(input logic [7:0] a, input logic [7:0] b, input logic [15:0] acc);
      s_a = a; s_b = b; s_acc_in = acc;
   endtask

   task automatic edge_then_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests    = 0;
      failures = 0;
      reset    = 1'b1;
      drive_u(8'd3, 8'd4, 16'd5);
      drive_s(8'd3, 8'd4, 16'd5);

      // Reset takes effect with no clock edge (first rising edge is at 5 ns).
      #2 reset = 1'b0;
      #1;
      check("reset_noedge_u", u_acc_out, 16'h0000);
      check("reset_noedge_s", s_acc_out, 16'h0000);

      // Still 0 after an edge while reset is held.
      @(negedge clk);
      check("reset_held_u", u_acc_out, 16'h0000);
      check("reset_held_s", s_acc_out, 16'h0000);

      // Single MAC.
      reset = 1'b1;
      drive_u(8'd3, 8'd4, 16'd0);
      drive_s(8'hFF, 8'd2, 16'h0005);
      edge_then_settle();
      check("single_u", u_acc_out, 16'd12);
      check("signed_neg_operand", s_acc_out, 16'h0003);

      // Chained accumulation: 12 + 2*5.
      @(negedge clk);
      drive_u(8'd2, 8'd5, 16'd12);
      drive_s(8'h80, 8'h80, 16'h7FFF);
      edge_then_settle();
      check("chained_u", u_acc_out, 16'd22);
      check("signed_ovf_pos", s_acc_out, EXP_S_OVF_POS);

      // Unsigned overflow: 0xFE01 + 0xFFFF.
      @(negedge clk);
      drive_u(8'd255, 8'd255, 16'hFFFF);
      drive_s(8'h80, 8'h7F, 16'h8000);
      edge_then_settle();
      check("unsigned_ovf", u_acc_out, EXP_U_OVF);
      check("signed_ovf_neg", s_acc_out, EXP_S_OVF_NEG);

      // Exactly at the top of range: no overflow in either build.
      @(negedge clk);
      drive_u(8'd255, 8'd255, 16'h01FE);
      drive_s(8'h7F, 8'h7F, 16'h40FE);
      edge_then_settle();
      check("unsigned_at_max", u_acc_out, 16'hFFFF);
      check("signed_at_max", s_acc_out, 16'h7FFF);

      // Zero operands pass acc_in through.
      @(negedge clk);
      drive_u(8'd0, 8'd77, 16'd1234);
      drive_s(8'h55, 8'h00, 16'h8000);
      edge_then_settle();
      check("zero_a_u", u_acc_out, 16'd1234);
      check("zero_b_s", s_acc_out, 16'h8000);

      @(negedge clk);
      drive_u(8'd99, 8'd0, 16'hFFFF);
      drive_s(8'h00, 8'hFF, 16'hFFFE);
      edge_then_settle();
      check("zero_b_u", u_acc_out, 16'hFFFF);
      check("zero_a_s", s_acc_out, 16'hFFFE);

      // Signed negative result: -3 * 5 + 0 = -15.
      @(negedge clk);
      drive_u(8'd10, 8'd10, 16'd100);
      drive_s(8'hFD, 8'd5, 16'h0000);
      edge_then_settle();
      check("unsigned_plain", u_acc_out, 16'd200);
      check("signed_negative", s_acc_out, 16'hFFF1);

      // Async reset mid-stream, between edges.
      @(negedge clk);
      drive_u(8'd9, 8'd9, 16'd1);
      drive_s(8'd9, 8'd9, 16'd1);
      #2 reset = 1'b0;
      #1;
      check("midreset_u", u_acc_out, 16'h0000);
      check("midreset_s", s_acc_out, 16'h0000);
      drive_u(8'd1, 8'd1, 16'd7);
      drive_s(8'd1, 8'd1, 16'd7);
      @(negedge clk);
      check("midreset_held_u", u_acc_out, 16'h0000);
      reset = 1'b1;
      edge_then_settle();
      check("release_u", u_acc_out, 16'd8);
      check("release_s", s_acc_out, 16'd8);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
